pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates per-latch enable and flush for load-use stalls, EX-stage redirects, data-memory waits and halt draining. It also gates instruction fetch while a data access owns the shared memory port, and counts stall cycles. It sits beside the datapath, consuming decode/execute/memory stage fields and cache hit signals.

Parameters:
REG_W, 5, register index width
CNT_W, 32, width of stall cycle counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction cache hit this cycle
dhit  in  1  data cache hit this cycle
de_rs  in  REG_W  rs field of instruction in IF/ID output
de_rt  in  REG_W  rt field of instruction in IF/ID output
de_halt  in  1  IF/ID output instruction is HALT
ex_dREN  in  1  ID/EX output instruction is a load
ex_RegWrite  in  1  ID/EX output instruction writes a register
ex_wsel  in  REG_W  ID/EX destination register
ex_redirect  in  1  branch taken / jump / jr resolved in EX
mem_dREN  in  1  EX/MEM output issues data read
mem_dWEN  in  1  EX/MEM output issues data write
wb_halt  in  1  MEM/WB output instruction is HALT
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC advance enables
ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert
imem_ren  out  1  instruction fetch request
halted  out  1  sticky halt indication
state_o  out  2  current FSM state (RUN=0, DWAIT=1, DRAIN=2, HALTED=3)
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 before HALTED

Behaviour:
- Reset (nRST=0, async): state=RUN, halted=0, stall_cycles=0. Outputs then evaluate combinationally from RUN.
- mem_req = mem_dREN|mem_dWEN. freeze = mem_req & !dhit.
- load_use = ex_dREN & ex_RegWrite & (ex_wsel!=0) & (ex_wsel==de_rs | ex_wsel==de_rt).
- Priority, highest first: HALTED > freeze > ex_redirect > load_use > !ihit > normal.
- HALTED: every enable and every flush = 0, imem_ren=0, halted=1. Exits only on reset.
- freeze (RUN/DRAIN/DWAIT): all enables 0, no flush, imem_ren=0. Next state DWAIT, or stay in DRAIN if in DRAIN.
- DWAIT: imem_ren=0 while !dhit. Cycle with dhit=1 is evaluated as RUN using the lower priorities. Next state RUN.
- ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1, remaining enables 1. Redirect wins over load_use in the same cycle.
- load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble per load; the condition clears the next cycle.
- !ihit (no higher event): pc_en=0, ifid_flush=1, downstream enables 1.
- normal: all enables 1, no flush, imem_ren=1.
- Flush takes precedence over its latch enable inside the latch. The controller never asserts en=0 together with flush=1 on the same latch.
- RUN & de_halt & no higher event: pc_en=0, ifid_flush=1, next state DRAIN.
- DRAIN: pc_en=0, imem_ren=0, ifid_flush=1 every cycle; downstream advances subject to freeze. wb_halt=1 moves the FSM to HALTED on the next edge.
- wb_halt in any state forces next state HALTED.
- stall_cycles: +1 on each edge where pc_en=0 and state!=HALTED. Saturates at all-ones; no wrap.
- Mid-operation reset: FSM returns to RUN asynchronously; counter clears; no pending DWAIT/DRAIN survives.

Decomposition:
- Shared package gets a ctrl_state_t enum (RUN, DWAIT, DRAIN, HALTED) and a latch_ctrl_t struct {en, flush} reused by all pipeline latches.
- One sub-module is natural: hazard_detect, purely combinational, computing load_use from the rs/rt/wsel fields. FSM, priority mux and counter live in the top.

Test Plan:
- Reset mid-DWAIT: assert nRST=0 while in DWAIT -> state_o=0, stall_cycles=0, halted=0 immediately.
- Load-use: ex_dREN=1, ex_RegWrite=1, ex_wsel=8, de_rs=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; normal enables the next cycle.
- Redirect plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1; no stall.
- Data miss: mem_dREN=1, dhit=0 for 3 cycles then 1 -> all enables 0 and imem_ren=0 for 3 cycles, state DWAIT, stall_cycles +3; cycle 4 returns to RUN.
- Halt: de_halt=1 -> DRAIN, pc_en=0; wb_halt=1 two cycles later -> HALTED, halted=1, all enables 0 indefinitely.
- Counter saturation: preload by forcing CNT_W=4, 20 stall cycles -> stall_cycles=15 and holds.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// per-latch enable/flush pair used by every pipeline register.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

  localparam latch_ctrl_t LATCH_ADV  = '{en: 1'b1, flush: 1'b0};
  localparam latch_ctrl_t LATCH_HOLD = '{en: 1'b0, flush: 1'b0};
  localparam latch_ctrl_t LATCH_BUB  = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is a source of the
// instruction currently in decode.
module pipeline_hazard_ctrl_hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_de_rs,
  input  logic [REG_W-1:0] i_de_rt,
  input  logic             i_ex_dREN,
  input  logic             i_ex_RegWrite,
  input  logic [REG_W-1:0] i_ex_wsel,
  output logic             o_load_use
);

  logic w_dest_live;
  logic w_src_match;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_dest_live = i_ex_dREN & i_ex_RegWrite & (i_ex_wsel != '0);
  assign w_src_match = (i_ex_wsel == i_de_rs) | (i_ex_wsel == i_de_rt);
  assign o_load_use  = w_dest_live & w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-latch enable/flush, fetch gating, halt draining
// and a saturating stall-cycle counter for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] de_rs,
  input  logic [REG_W-1:0] de_rt,
  input  logic             de_halt,
  input  logic             ex_dREN,
  input  logic             ex_RegWrite,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_redirect,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             imem_ren,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  latch_ctrl_t      w_ifid, w_idex, w_exmem, w_memwb;
  logic             w_pc_en;
  logic             w_imem_ren;
  logic             w_freeze;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_cnt;

  pipeline_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_de_rs       (de_rs),
    .i_de_rt       (de_rt),
    .i_ex_dREN     (ex_dREN),
    .i_ex_RegWrite (ex_RegWrite),
    .i_ex_wsel     (ex_wsel),
    .o_load_use    (w_load_use)
  );

  // A pending data access owns the shared memory port until it hits.
  assign w_freeze = (mem_dREN | mem_dWEN) & ~dhit;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_pc_en    = 1'b1;
    w_ifid     = LATCH_ADV;
    w_idex     = LATCH_ADV;
    w_exmem    = LATCH_ADV;
    w_memwb    = LATCH_ADV;
    w_imem_ren = 1'b1;
    w_next     = RUN;

    if (r_state == HALTED) begin
      w_pc_en    = 1'b0;
      w_ifid     = LATCH_HOLD;
      w_idex     = LATCH_HOLD;
      w_exmem    = LATCH_HOLD;
      w_memwb    = LATCH_HOLD;
      w_imem_ren = 1'b0;
      w_next     = HALTED;
    end else if (w_freeze) begin
      w_pc_en    = 1'b0;
      w_ifid     = LATCH_HOLD;
      w_idex     = LATCH_HOLD;
      w_exmem    = LATCH_HOLD;
      w_memwb    = LATCH_HOLD;
      w_imem_ren = 1'b0;
      w_next     = (r_state == DRAIN) ? DRAIN : DWAIT;
    end else if (r_state == DRAIN) begin
      w_pc_en    = 1'b0;
      w_ifid     = LATCH_BUB;
      w_imem_ren = 1'b0;
      w_next     = DRAIN;
    end else begin
      // DWAIT without a freeze behaves as RUN; fetch stays off until dhit.
      if (r_state == DWAIT && !dhit) w_imem_ren = 1'b0;
      if (ex_redirect) begin
        w_ifid = LATCH_BUB;
        w_idex = LATCH_BUB;
      end else if (w_load_use) begin
        w_pc_en = 1'b0;
        w_ifid  = LATCH_HOLD;
        w_idex  = LATCH_BUB;
      end else if (de_halt) begin
        w_pc_en = 1'b0;
        w_ifid  = LATCH_BUB;
        w_next  = DRAIN;
      end else if (!ihit) begin
        w_pc_en = 1'b0;
        w_ifid  = LATCH_BUB;
      end
    end

    if (wb_halt) w_next = HALTED;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != HALTED && !w_pc_en && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_en        = w_pc_en;
  assign ifid_en      = w_ifid.en;
  assign ifid_flush   = w_ifid.flush;
  assign idex_en      = w_idex.en;
  assign idex_flush   = w_idex.flush;
  assign exmem_en     = w_exmem.en;
  assign exmem_flush  = w_exmem.flush;
  assign memwb_en     = w_memwb.en;
  assign imem_ren     = w_imem_ren;
  assign halted       = (r_state == HALTED);
  assign state_o      = r_state;
  assign stall_cycles = r_stall_cnt;

endmodule
